// File: rtl/i2c_apb_pkg.sv
// Shared definitions for the APB arbiter in front of the I2C master register block.
package i2c_apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } apb_state_e;

  // I2C master register map as seen by the requesters
  localparam logic [7:0] I2C_ADDR_PRER_LO = 8'h00;
  localparam logic [7:0] I2C_ADDR_PRER_HI = 8'h01;
  localparam logic [7:0] I2C_ADDR_CTR     = 8'h02;
  localparam logic [7:0] I2C_ADDR_TXR     = 8'h03;
  localparam logic [7:0] I2C_ADDR_CR      = 8'h04;
  localparam logic [7:0] I2C_ADDR_SR      = 8'h05;

endpackage

// File: rtl/i2c_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module i2c_rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             vld_o
);

  // Scan from the farthest offset down so the nearest request is assigned last and wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % N]) begin
        gnt_o = '0;
        gnt_o[(int'(ptr_i) + i) % N] = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + i) % N);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_apb_arbiter.sv
// APB master sharing the I2C register port between NUM_REQ requesters, one transfer per
// round-robin grant, with a PREADY timeout so a stalled slave cannot hang the bus.
module i2c_apb_arbiter
  import i2c_apb_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 8,
  parameter int NUM_REQ   = 2,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic                           pclk_i,
  input  logic                           preset_i,
  input  logic [NUM_REQ-1:0]             req_i,
  input  logic [NUM_REQ*ADDR_SIZE-1:0]   addr_i,
  input  logic [NUM_REQ-1:0]             write_i,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]             done_o,
  output logic                           err_o,
  output logic [DATA_SIZE-1:0]           rdata_o,
  output logic                           busy_o,
  output logic [ADDR_SIZE-1:0]           paddr_o,
  output logic                           pwrite_o,
  output logic                           psel_o,
  output logic                           penable_o,
  output logic [DATA_SIZE-1:0]           pwdata_o,
  input  logic [DATA_SIZE-1:0]           prdata_i,
  input  logic                           pready_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  apb_state_e           state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, gidx_q, gidx_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d;
  logic [TO_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] paddr_q, paddr_d;
  logic [DATA_SIZE-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
  logic                 pwrite_q, pwrite_d, err_q, err_d;
  logic                 psel_q, psel_d, penable_q, penable_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_vld;

  i2c_rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    done_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          gidx_d   = arb_idx;
          gnt_d    = arb_gnt;
          paddr_d  = addr_i[int'(arb_idx)*ADDR_SIZE +: ADDR_SIZE];
          pwrite_d = write_i[arb_idx];
          pwdata_d = wdata_i[int'(arb_idx)*DATA_SIZE +: DATA_SIZE];
          state_d  = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // A PREADY arriving on the timeout cycle still completes the transfer normally.
        if (pready_i) begin
          rdata_d = pwrite_q ? '0 : prdata_i;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (TIMEOUT != 0 && cnt_d == TO_W'(TIMEOUT)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end
        if (state_d == ST_DONE) done_d = gnt_q;
      end
      ST_DONE: begin
        ptr_d   = (int'(gidx_q) == NUM_REQ - 1) ? '0 : gidx_q + 1'b1;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Strobes come straight from flops so they cannot glitch between states.
    psel_d    = (state_d == ST_SETUP) || (state_d == ST_ACCESS);
    penable_d = (state_d == ST_ACCESS);
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      gidx_q    <= '0;
      gnt_q     <= '0;
      cnt_q     <= '0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      done_q    <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gidx_q    <= gidx_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      done_q    <= done_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
    end
  end

  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign busy_o    = (state_q != ST_IDLE);
  assign paddr_o   = paddr_q;
  assign pwrite_o  = pwrite_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Randomized transaction-level check of the APB arbiter against a round-robin / timeout model.
module tb_i2c_apb_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NR = 2;
  localparam int TO = 4;

  logic             pclk_i = 1'b0;
  logic             preset_i = 1'b1;
  logic [NR-1:0]    req_i = '0;
  logic [NR*AW-1:0] addr_i = '0;
  logic [NR-1:0]    write_i = '0;
  logic [NR*DW-1:0] wdata_i = '0;
  logic [NR-1:0]    done_o;
  logic             err_o;
  logic [DW-1:0]    rdata_o;
  logic             busy_o;
  logic [AW-1:0]    paddr_o;
  logic             pwrite_o;
  logic             psel_o;
  logic             penable_o;
  logic [DW-1:0]    pwdata_o;
  logic [DW-1:0]    prdata_i = '0;
  logic             pready_i = 1'b0;

  i2c_apb_arbiter #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .NUM_REQ(NR), .TIMEOUT(TO), .TO_W(8)) dut (
    .pclk_i(pclk_i), .preset_i(preset_i), .req_i(req_i), .addr_i(addr_i), .write_i(write_i),
    .wdata_i(wdata_i), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o), .busy_o(busy_o),
    .paddr_o(paddr_o), .pwrite_o(pwrite_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i)
  );

  always #5 pclk_i = ~pclk_i;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          ptr_m = 0;
  logic        last_err = 1'b0;
  logic [7:0]  last_rd = '0;
  logic [1:0]  obs_done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [1:0] rq, input int p);
    for (int i = 0; i < NR; i++)
      if (rq[(p + i) % NR]) return (p + i) % NR;
    return -1;
  endfunction

  task automatic do_reset();
    preset_i = 1'b1;
    req_i = '0;
    pready_i = 1'b0;
    @(posedge pclk_i); #1;
    @(posedge pclk_i); #1;
    chk("rst_psel", psel_o, 0);
    chk("rst_pen", penable_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_paddr", paddr_o, 0);
    chk("rst_pwdata", pwdata_o, 0);
    preset_i = 1'b0;
    ptr_m = 0;
    last_err = 1'b0;
    last_rd = '0;
  endtask

  // Entered at posedge+1 of an IDLE cycle; rq must be nonzero. w = wait states before PREADY.
  task automatic do_xfer(input logic [1:0] rq, input int w, input bit drop, input logic [7:0] prd);
    int g, alen;
    logic [7:0] ea, ed, rd;
    logic ew, eerr;
    req_i = rq;
    g  = rr_pick(rq, ptr_m);
    ea = addr_i[g*AW +: AW];
    ew = write_i[g];
    ed = wdata_i[g*DW +: DW];
    @(negedge pclk_i);
    chk("idle_busy", busy_o, 0);
    chk("idle_psel", psel_o, 0);
    chk("idle_done", done_o, 0);
    chk("hold_err", err_o, last_err);
    chk("hold_rdata", rdata_o, last_rd);
    @(posedge pclk_i); #1;
    // grant is taken; anything the requesters do now must be ignored
    addr_i = $urandom; wdata_i = $urandom; write_i = 2'($urandom);
    if (drop) req_i[g] = 1'b0;
    @(negedge pclk_i);
    chk("setup_psel", psel_o, 1);
    chk("setup_pen", penable_o, 0);
    chk("setup_paddr", paddr_o, ea);
    chk("setup_pwrite", pwrite_o, ew);
    chk("setup_pwdata", pwdata_o, ed);
    chk("setup_busy", busy_o, 1);
    eerr = (w >= TO);
    alen = eerr ? TO : w + 1;
    rd = '0;
    for (int c = 0; c < alen; c++) begin
      @(posedge pclk_i); #1;
      pready_i = (c == w);
      prdata_i = (c == w) ? prd : 8'($urandom);
      if (c == w) rd = prd;
      addr_i = $urandom;
      @(negedge pclk_i);
      chk("acc_psel", psel_o, 1);
      chk("acc_pen", penable_o, 1);
      chk("acc_paddr", paddr_o, ea);
      chk("acc_pwdata", pwdata_o, ed);
      chk("acc_done", done_o, 0);
    end
    @(posedge pclk_i); #1;
    pready_i = 1'b0;
    prdata_i = $urandom;
    @(negedge pclk_i);
    obs_done = done_o;
    chk("done_vec", done_o, 2'b01 << g);
    chk("done_err", err_o, eerr);
    chk("done_rdata", rdata_o, (eerr || ew) ? 8'h00 : rd);
    chk("done_psel", psel_o, 0);
    chk("done_pen", penable_o, 0);
    chk("done_busy", busy_o, 1);
    last_err = eerr;
    last_rd  = (eerr || ew) ? 8'h00 : rd;
    ptr_m    = (g + 1) % NR;
    @(posedge pclk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    do_reset();

    // single write, zero wait states
    addr_i = {8'h00, 8'h02}; wdata_i = {8'h00, 8'hA5}; write_i = 2'b01;
    do_xfer(2'b01, 0, 0, 8'h00);
    chk("wr_done", obs_done, 2'b01);

    // read from requester 1 with 3 wait states; PREADY lands on the timeout cycle and wins
    addr_i = {8'h05, 8'h00}; write_i = 2'b00;
    do_xfer(2'b10, 3, 0, 8'h3C);
    chk("rd_done", obs_done, 2'b10);
    chk("rd_data", rdata_o, 8'h3C);

    // contention from reset: strict alternation
    do_reset();
    for (int k = 0; k < 4; k++) begin
      addr_i = $urandom; wdata_i = $urandom; write_i = 2'($urandom);
      do_xfer(2'b11, 0, 0, 8'($urandom));
      chk("cont_order", obs_done, (k % 2 == 0) ? 2'b01 : 2'b10);
    end

    // timeout then a normal transfer clears err
    addr_i = $urandom; write_i = 2'b00;
    do_xfer(2'b01, 10, 0, 8'h77);
    chk("to_err", err_o, 1);
    addr_i = $urandom; write_i = 2'b00;
    do_xfer(2'b01, 0, 0, 8'h5A);
    chk("to_recover", err_o, 0);

    // reset during an ACCESS wait state of requester 1
    addr_i = $urandom; write_i = 2'b00;
    req_i = 2'b10;
    @(posedge pclk_i); #1;
    @(posedge pclk_i); #1;
    pready_i = 1'b0;
    #2 preset_i = 1'b1;
    #1;
    chk("arst_psel", psel_o, 0);
    chk("arst_pen", penable_o, 0);
    chk("arst_busy", busy_o, 0);
    chk("arst_done", done_o, 0);
    @(posedge pclk_i); #1;
    preset_i = 1'b0;
    ptr_m = 0; last_err = 1'b0; last_rd = '0;
    addr_i = $urandom; wdata_i = $urandom; write_i = 2'($urandom);
    do_xfer(2'b11, 1, 0, 8'($urandom));
    chk("arst_first", obs_done, 2'b01);

    // requester drops req during SETUP: completes, no second transfer
    addr_i = $urandom; wdata_i = $urandom; write_i = 2'($urandom);
    do_xfer(2'b01, 0, 1, 8'($urandom));
    chk("drop_done", obs_done, 2'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk_i);
      chk("drop_idle_psel", psel_o, 0);
      chk("drop_idle_busy", busy_o, 0);
    end
    @(posedge pclk_i); #1;

    // random traffic
    for (int n = 0; n < 150; n++) begin
      addr_i = $urandom; wdata_i = $urandom; write_i = 2'($urandom);
      do_xfer(2'($urandom_range(1, 3)), $urandom_range(0, 6), ($urandom_range(0, 3) == 0),
              8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_apb_arbiter.md
Name: i2c_apb_arbiter

Overview:
APB bus master that shares the single APB slave port of the I2C master controller between NUM_REQ requesters, e.g. a CPU bridge and an autonomous command sequencer. It arbitrates round-robin, runs one APB transfer (SETUP, ACCESS, wait PREADY) per grant, and returns read data with a one-cycle completion pulse. A PREADY timeout guarantees forward progress if the I2C register block stalls.

Parameters:
DATA_SIZE, 8, APB data width
ADDR_SIZE, 8, APB address width
NUM_REQ, 2, number of requesters (>=2)
TIMEOUT, 255, max ACCESS cycles waiting for pready_i before abort; 0 disables timeout
TO_W, 8, timeout counter width (must hold TIMEOUT)

Ports:
pclk_i  in  1  clock (APB clock domain)
preset_i  in  1  asynchronous reset, active-high
req_i  in  NUM_REQ  per-requester transfer request, level, held until done
addr_i  in  NUM_REQ*ADDR_SIZE  flattened per-requester address; slice k belongs to requester k
write_i  in  NUM_REQ  per-requester direction, 1 = write
wdata_i  in  NUM_REQ*DATA_SIZE  flattened per-requester write data
done_o  out  NUM_REQ  one-cycle completion pulse for granted requester
err_o  out  1  timeout flag, valid with done_o
rdata_o  out  DATA_SIZE  read data, valid with done_o
busy_o  out  1  transfer in progress (state != IDLE)
paddr_o  out  ADDR_SIZE  APB address
pwrite_o  out  1  APB direction
psel_o  out  1  APB select
penable_o  out  1  APB enable
pwdata_o  out  DATA_SIZE  APB write data
prdata_i  in  DATA_SIZE  APB read data
pready_i  in  1  APB ready

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0. Round-robin pointer = 0, so requester 0 has highest priority. Timeout counter = 0. Any in-flight transfer is dropped with no done_o.
- FSM states: IDLE, SETUP, ACCESS, DONE.
- IDLE: if any req_i is set, grant the first set bit searching from the pointer upward with wrap. Latch that requester's addr, write and wdata into paddr_o/pwrite_o/pwdata_o. Record grant index g. Go to SETUP. Otherwise stay, with psel_o=0.
- SETUP: psel_o=1, penable_o=0. Go to ACCESS.
- ACCESS: psel_o=1, penable_o=1, paddr/pwrite/pwdata held stable.
  - If pready_i=1: capture prdata_i into rdata_o for reads; rdata_o=0 for writes. err=0. Go to DONE.
  - Else increment the timeout counter. If TIMEOUT!=0 and the counter reaches TIMEOUT: rdata_o=0, err=1, go to DONE.
  - pready_i wins if it arrives in the same cycle the timeout is reached.
- DONE: psel_o=0, penable_o=0. done_o[g]=1 for exactly this cycle; err_o and rdata_o are valid. Pointer becomes (g+1) mod NUM_REQ. Counter clears. Go to IDLE. No arbitration happens in DONE; the requester drops req_i on seeing done.
- err_o and rdata_o hold their values until the next DONE.
- Minimum transfer with zero-wait pready is 4 cycles, grant to grant: IDLE, SETUP, ACCESS, DONE.
- Inputs of non-granted requesters are ignored during a transfer. The granted requester's inputs are not re-sampled after IDLE.
- req_i deasserted mid-transfer: the transfer completes normally and done_o still pulses.
- Requester still holding req_i in the IDLE after its done is treated as a new request, with lowest priority.
- psel_o/penable_o never glitch. penable_o=1 only when psel_o=1 and the FSM is in ACCESS.
- busy_o=1 in SETUP, ACCESS and DONE.

Decomposition:
- Shared package i2c_apb_pkg: FSM state encoding (IDLE=0, SETUP=1, ACCESS=2, DONE=3) and the I2C register address constants used by requesters.
- One natural sub-module: i2c_rr_arbiter. Combinational round-robin picker with inputs req vector and pointer, outputs one-hot grant and encoded index. Pointer register stays in the parent.

Test Plan:
- Single write: req_i=01, addr0=0x02, wdata0=0xA5, pready_i tied 1. Required: psel_o high 2 cycles, penable_o in the 2nd cycle, paddr_o=0x02, pwdata_o=0xA5, done_o=01 on cycle 4, err_o=0.
- Read with wait states: req1 read addr=0x05, pready_i held 0 for 3 ACCESS cycles then 1 with prdata_i=0x3C. Required: penable_o high 4 cycles, then done_o=10, rdata_o=0x3C.
- Contention: both req_i held continuously from reset. Required: grants alternate 0,1,0,1 across 4 transfers, with each done_o pulse exactly 1 cycle.
- Timeout: TIMEOUT=4, pready_i held 0. Required: ACCESS lasts 4 cycles, then psel_o drops, done_o pulses with err_o=1, rdata_o=0. A subsequent normal transfer gives err_o=0.
- Reset mid-ACCESS: assert preset_i asynchronously during a wait state. Required: psel_o/penable_o go to 0 immediately, no done_o, and after release requester 0 wins the first grant.
- Req drop: deassert req0 during SETUP. Required: transfer still completes, done_o=01 is pulsed, and no second transfer is issued.
